// File: rtl/mario_pkg.sv
// Shared types, constants and sprite art for the Mario sprite fetch stage.
package mario_pkg;

    localparam int unsigned SPRITE_W  = 16;
    localparam int unsigned ANIM_DIV  = 4;
    localparam int unsigned NUM_WALK  = 3;
    localparam int unsigned NUM_FRAME = NUM_WALK + 2;
    localparam int unsigned ROM_DEPTH = NUM_FRAME * SPRITE_W * SPRITE_W;
    localparam int unsigned ROM_AW    = 11;

    typedef logic [3:0] pal_idx_t;

    localparam pal_idx_t TRANSPARENT_IDX = 4'h0;

    typedef enum logic [2:0] {
        FR_STAND = 3'd0,
        FR_WALK1 = 3'd1,
        FR_WALK2 = 3'd2,
        FR_WALK3 = 3'd3,
        FR_JUMP  = 3'd4
    } frame_e;

    typedef enum logic {
        FACE_RIGHT = 1'b0,
        FACE_LEFT  = 1'b1
    } face_e;

    // Sprite art as a closed-form table: addr = {frame, row, col}.
    // Cross term row*col keeps columns asymmetric so mirroring is visible.
    // Addresses beyond the last frame read as transparent.
    function automatic pal_idx_t sprite_art(logic [ROM_AW-1:0] addr);
        logic [7:0] f;
        logic [7:0] r;
        logic [7:0] c;
        logic [7:0] s;
        f = {5'd0, addr[10:8]};
        r = {4'd0, addr[7:4]};
        c = {4'd0, addr[3:0]};
        s = f * 8'd7 + r * 8'd5 + c * 8'd3 + r * c;
        if (addr[10:8] > FR_JUMP) begin
            return TRANSPARENT_IDX;
        end
        return s[3:0];
    endfunction

endpackage

// File: rtl/mario_sprite_rom.sv
// 1280x4 synchronous-read sprite ROM; one-cycle read latency.
module mario_sprite_rom
    import mario_pkg::*;
(
    input  logic              clk_i,
    input  logic [ROM_AW-1:0] addr_i,
    output pal_idx_t          data_o
);

    pal_idx_t data_d;
    pal_idx_t data_q;

    // Table lookup for the addressed pixel.
    always_comb begin
        data_d = sprite_art(addr_i);
    end

    // Registered read port.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/mario_sprite_fetch.sv
// Per-pixel Mario sprite fetch: per-frame state latch with walk animation,
// plus a fixed two-stage pixel pipeline into the sprite ROM.
module mario_sprite_fetch
    import mario_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       pixel_valid,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    output pal_idx_t   sprite_pix_idx,
    output logic       sprite_hit,
    output logic       sprite_valid
);

    localparam int unsigned ANIM_W = $clog2(ANIM_DIV);
    localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
    localparam frame_e LAST_WALK = frame_e'(3'(NUM_WALK));
    localparam logic [10:0] SPRITE_W11 = 11'(SPRITE_W);

    // Only the 16-pixel size is supported; the size input is intentionally ignored.
    logic unused_ball_s;
    assign unused_ball_s = ^BallS;

    // Frame-latched Mario state
    logic [9:0]        cur_x_q, cur_x_d;
    logic [9:0]        cur_y_q, cur_y_d;
    face_e             facing_q, facing_d;
    frame_e            walk_frame_q, walk_frame_d;
    frame_e            frame_sel_q, frame_sel_d;
    logic [ANIM_W-1:0] anim_cnt_q, anim_cnt_d;

    // Pipeline stages
    logic              s1_in_box_q, s1_in_box_d;
    logic              s1_valid_q, s1_valid_d;
    logic [ROM_AW-1:0] s1_addr_q, s1_addr_d;
    logic              s2_in_box_q, s2_in_box_d;
    logic              s2_valid_q, s2_valid_d;
    pal_idx_t          rom_q;

    // Frame latch: facing, animation counter and frame select from the motion deltas.
    always_comb begin
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        facing_d     = facing_q;
        walk_frame_d = walk_frame_q;
        frame_sel_d  = frame_sel_q;
        anim_cnt_d   = anim_cnt_q;
        if (frame_start) begin
            if (BallX > cur_x_q) begin
                facing_d = FACE_RIGHT;
            end else if (BallX < cur_x_q) begin
                facing_d = FACE_LEFT;
            end
            if (BallX != cur_x_q) begin
                if (anim_cnt_q == ANIM_LAST) begin
                    anim_cnt_d = '0;
                    if (walk_frame_q == FR_STAND || walk_frame_q >= LAST_WALK) begin
                        walk_frame_d = FR_WALK1;
                    end else begin
                        walk_frame_d = frame_e'(walk_frame_q + 3'd1);
                    end
                end else begin
                    anim_cnt_d = anim_cnt_q + 1'b1;
                end
            end else begin
                anim_cnt_d   = '0;
                walk_frame_d = FR_STAND;
            end
            // Rising beats walking
            frame_sel_d = (BallY < cur_y_q) ? FR_JUMP : walk_frame_d;
            cur_x_d     = BallX;
            cur_y_d     = BallY;
        end
    end

    // S1: box test against the pre-latch position and ROM address formation.
    always_comb begin
        logic [10:0] x_end;
        logic [10:0] y_end;
        logic [3:0]  col;
        logic [3:0]  row;
        // 11-bit ends so a sprite near the right/bottom edge clips instead of wrapping
        x_end = {1'b0, cur_x_q} + SPRITE_W11;
        y_end = {1'b0, cur_y_q} + SPRITE_W11;
        col   = DrawX[3:0] - cur_x_q[3:0];
        row   = DrawY[3:0] - cur_y_q[3:0];
        s1_in_box_d = pixel_valid
                      && (DrawX >= cur_x_q) && ({1'b0, DrawX} < x_end)
                      && (DrawY >= cur_y_q) && ({1'b0, DrawY} < y_end);
        s1_valid_d  = pixel_valid;
        s1_addr_d   = {frame_sel_q, row, (facing_q == FACE_LEFT) ? ~col : col};
        s2_in_box_d = s1_in_box_q;
        s2_valid_d  = s1_valid_q;
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            facing_q     <= FACE_RIGHT;
            walk_frame_q <= FR_STAND;
            frame_sel_q  <= FR_STAND;
            anim_cnt_q   <= '0;
            s1_in_box_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s2_in_box_q  <= 1'b0;
            s2_valid_q   <= 1'b0;
        end else begin
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            facing_q     <= facing_d;
            walk_frame_q <= walk_frame_d;
            frame_sel_q  <= frame_sel_d;
            anim_cnt_q   <= anim_cnt_d;
            s1_in_box_q  <= s1_in_box_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s2_in_box_q  <= s2_in_box_d;
            s2_valid_q   <= s2_valid_d;
        end
    end

    mario_sprite_rom u_rom (
        .clk_i  (Clk),
        .addr_i (s1_addr_q),
        .data_o (rom_q)
    );

    // Outputs: gate the ROM word with the delayed box flag.
    always_comb begin
        sprite_pix_idx = s2_in_box_q ? rom_q : TRANSPARENT_IDX;
        sprite_hit     = s2_in_box_q && (rom_q != TRANSPARENT_IDX);
        sprite_valid   = s2_valid_q;
    end

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Self-checking bench: directed scenarios plus randomized frames/pixels
// compared cycle by cycle against a behavioural sprite model.
module tb_mario_sprite_fetch;

    logic       Clk;
    logic       Reset;
    logic       frame_start;
    logic       pixel_valid;
    logic [9:0] DrawX, DrawY, BallX, BallY, BallS;
    logic [3:0] sprite_pix_idx;
    logic       sprite_hit;
    logic       sprite_valid;

    int n_vec;
    int n_err;

    // Sprite art: 5 frames of 16x16 palette indices
    int rom_tbl [0:4][0:15][0:15];

    // Model state (plain integers)
    int m_cx, m_cy, m_walk, m_cnt, m_sel;
    bit m_left;
    // One pending pixel result plus the one currently visible
    bit st_v, st_h, ex_v, ex_h;
    int st_idx, ex_idx;

    mario_sprite_fetch dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_start    (frame_start),
        .pixel_valid    (pixel_valid),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .BallX          (BallX),
        .BallY          (BallY),
        .BallS          (BallS),
        .sprite_pix_idx (sprite_pix_idx),
        .sprite_hit     (sprite_hit),
        .sprite_valid   (sprite_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cx = 0; m_cy = 0; m_walk = 0; m_cnt = 0; m_sel = 0; m_left = 0;
    endtask

    task automatic model_pixel(output bit v, output bit h, output int idx);
        int x, y, col, row;
        bit in_box;
        x = int'(DrawX); y = int'(DrawY);
        in_box = pixel_valid && x >= m_cx && x < m_cx + 16 && y >= m_cy && y < m_cy + 16;
        v = pixel_valid;
        idx = 0;
        if (in_box) begin
            col = x - m_cx;
            row = y - m_cy;
            if (m_left) col = 15 - col;
            idx = rom_tbl[m_sel][row][col];
        end
        h = in_box && idx != 0;
    endtask

    task automatic model_latch();
        int bx, by;
        bx = int'(BallX); by = int'(BallY);
        if (bx > m_cx) m_left = 0;
        else if (bx < m_cx) m_left = 1;
        if (bx != m_cx) begin
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_walk = (m_walk >= 3) ? 1 : m_walk + 1;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
            m_walk = 0;
        end
        m_sel = (by < m_cy) ? 4 : m_walk;
        m_cx = bx;
        m_cy = by;
    endtask

    // One clock: advance the model with the inputs now driven, then compare.
    task automatic tick();
        bit nv, nh;
        int ni;
        model_pixel(nv, nh, ni);
        if (Reset) begin
            ex_v = 0; ex_h = 0; ex_idx = 0;
            st_v = 0; st_h = 0; st_idx = 0;
            model_reset();
        end else begin
            ex_v = st_v; ex_h = st_h; ex_idx = st_idx;
            st_v = nv; st_h = nh; st_idx = ni;
            if (frame_start) model_latch();
        end
        @(posedge Clk);
        #1;
        check_eq("valid", int'(sprite_valid), int'(ex_v));
        check_eq("hit", int'(sprite_hit), int'(ex_h));
        check_eq("idx", int'(sprite_pix_idx), ex_idx);
    endtask

    task automatic do_frame(input int bx, input int by);
        frame_start = 1'b1;
        BallX = 10'(bx);
        BallY = 10'(by);
        tick();
        frame_start = 1'b0;
    endtask

    // Present one pixel, then check it two edges later against fixed expectations.
    task automatic probe(input string tag, input int x, input int y, input int exp_idx);
        pixel_valid = 1'b1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
        pixel_valid = 1'b0;
        tick();
        check_eq({tag, "_idx"}, int'(sprite_pix_idx), exp_idx);
        check_eq({tag, "_hit"}, int'(sprite_hit), int'(exp_idx != 0));
        check_eq({tag, "_vld"}, int'(sprite_valid), 1);
    endtask

    int walk_seq [0:7] = '{0, 0, 0, 1, 1, 1, 1, 2};

    initial begin
        int bx, by, px, py;
        n_vec = 0;
        n_err = 0;
        for (int f = 0; f < 5; f++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    rom_tbl[f][r][c] = (f * 7 + r * 5 + c * 3 + r * c) % 16;
        model_reset();
        st_v = 0; st_h = 0; st_idx = 0;
        Reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0;
        DrawX = '0; DrawY = '0; BallX = '0; BallY = '0; BallS = 10'd16;

        // 1: reset state, then first sprite pixel
        tick();
        tick();
        check_eq("rst_idx", int'(sprite_pix_idx), 0);
        check_eq("rst_vld", int'(sprite_valid), 0);
        Reset = 1'b0;
        do_frame(100, 200);
        probe("t1", 100, 200, rom_tbl[0][0][0]);

        // 2: horizontal box edges
        probe("t2_left", 99, 205, 0);
        probe("t2_right", 116, 205, 0);
        probe("t2_col15", 115, 205, rom_tbl[0][5][15]);

        // 3: moving left mirrors the columns
        do_frame(98, 200);
        probe("t3_mirror", 98, 200, rom_tbl[0][0][15]);

        // 4: walk cycle, then standing
        do_frame(98, 200);
        bx = 98;
        for (int k = 0; k < 8; k++) begin
            bx += 2;
            do_frame(bx, 200);
            probe($sformatf("t4_walk%0d", k), bx + 3, 205, rom_tbl[walk_seq[k]][5][3]);
        end
        do_frame(bx, 200);
        probe("t4_stand", bx + 3, 205, rom_tbl[0][5][3]);

        // 5: rising selects the jump frame; right-edge clip
        bx += 2;
        do_frame(bx, 198);
        probe("t5_jump", bx + 3, 203, rom_tbl[4][5][3]);
        do_frame(630, 198);
        probe("t5_edge", 639, 203, rom_tbl[m_sel][5][9]);
        for (int x = 0; x < 6; x++) probe($sformatf("t5_nowrap%0d", x), x, 203, 0);

        // 6: reset with hits in flight, then frame_start coinciding with a pixel
        pixel_valid = 1'b1; DrawX = 10'd635; DrawY = 10'd200;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        check_eq("t6_rst_idx", int'(sprite_pix_idx), 0);
        check_eq("t6_rst_hit", int'(sprite_hit), 0);
        check_eq("t6_rst_vld", int'(sprite_valid), 0);
        Reset = 1'b0; pixel_valid = 1'b0;
        tick();
        do_frame(100, 200);
        frame_start = 1'b1; BallX = 10'd300; BallY = 10'd200;
        pixel_valid = 1'b1; DrawX = 10'd102; DrawY = 10'd205;
        tick();
        frame_start = 1'b0; pixel_valid = 1'b0;
        tick();
        check_eq("t6_old_pos", int'(sprite_pix_idx), rom_tbl[0][5][2]);

        // Randomized frames and pixels around the sprite
        for (int i = 0; i < 600; i++) begin
            Reset = ($urandom_range(0, 199) == 0);
            frame_start = ($urandom_range(0, 11) == 0);
            if (frame_start) begin
                bx = m_cx + $urandom_range(0, 6) - 3;
                by = m_cy + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) - 3 : 0);
                if ($urandom_range(0, 19) == 0) bx = $urandom_range(0, 1023);
                BallX = 10'(bx < 0 ? 0 : (bx > 1023 ? 1023 : bx));
                BallY = 10'(by < 0 ? 0 : (by > 1023 ? 1023 : by));
            end
            pixel_valid = ($urandom_range(0, 7) != 0);
            px = m_cx + $urandom_range(0, 23) - 4;
            py = m_cy + $urandom_range(0, 23) - 4;
            DrawX = 10'(px < 0 ? 0 : (px > 1023 ? 1023 : px));
            DrawY = 10'(py < 0 ? 0 : (py > 1023 ? 1023 : py));
            tick();
        end
        Reset = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
